i2c_bus_arbiter: RTL and testbench
==================================

Name: i2c_bus_arbiter

Overview:
Shares one i2c_master engine among N_REQ independent requesters, e.g. the AXI register port plus hardware pollers such as a sensor scanner. Each requester submits single-byte transactions over a valid/ready handshake. The block grants the engine round-robin, sequences start/busy/done, routes the result back to the owner, and enforces a completion timeout. It sits between the requesters and i2c_master; the IOBUF/pin side is unchanged.

Parameters:
N_REQ, 2, number of requesters (2..8)
TIMEOUT_CYCLES, 1000000, max clk cycles from m_start to m_done before timeout
CNT_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_valid  in  N_REQ  requester i has a transaction
req_ready  out  N_REQ  transaction i accepted (one-cycle pulse)
req_addr  in  7*N_REQ  slave address, slice i = [7i+6:7i]
req_rw  in  N_REQ  0 write, 1 read
req_wdata  in  8*N_REQ  write byte, slice i = [8i+7:8i]
rsp_valid  out  N_REQ  response for requester i pending
rsp_ready  in  N_REQ  requester i consumes response
rsp_rdata  out  8  read byte (valid with any rsp_valid)
rsp_ack_err  out  1  slave NACK
rsp_timeout  out  1  no done within TIMEOUT_CYCLES
m_start  out  1  one-cycle start pulse to i2c_master
m_addr  out  7  latched address
m_rw  out  1  latched r/w
m_wdata  out  8  latched write byte
m_busy  in  1  engine busy
m_done  in  1  one-cycle completion pulse; m_ack_error/m_rdata valid in same cycle
m_ack_error  in  1  NACK flag
m_rdata  in  8  read byte
grant_id  out  $clog2(N_REQ) (min 1)  current/last owner, debug

Behaviour:
- Reset (rst=1 at posedge): state IDLE; all outputs 0; rr pointer 0 (requester 0 highest priority first); timeout counter 0. Reset mid-transaction abandons it silently; no response issued.
- States: IDLE, ISSUE, WAIT_DONE, RESP, DRAIN.
- IDLE: if any req_valid, pick first set bit searching from rr pointer upward with wrap; same cycle pulse req_ready[g], latch addr/rw/wdata slices and grant_id=g; next state ISSUE. Do not grant while m_busy=1; stay IDLE.
- ISSUE: m_start=1 for exactly this cycle; clear counter; -> WAIT_DONE. m_addr/m_rw/m_wdata are held stable from latch until next grant.
- WAIT_DONE: counter increments each cycle. m_done=1 -> capture m_rdata, m_ack_error into rsp regs, rsp_timeout=0, -> RESP. Else if counter reaches TIMEOUT_CYCLES-1 -> rsp_timeout=1, rsp_ack_err=0, rsp_rdata=0, -> RESP. If m_done and the limit coincide, done wins.
- RESP: rsp_valid[grant_id]=1, all other bits 0; rsp_* held stable until rsp_ready[grant_id]=1, then rr pointer = grant_id+1 (mod N_REQ). Next state is DRAIN if rsp_timeout=1, otherwise IDLE. rsp_ready bits of non-owners are ignored.
- DRAIN: wait until m_busy=0, then -> IDLE. A late m_done is ignored.
- Latency: req_ready at the grant cycle; m_start 1 cycle later. rsp_valid is asserted the cycle after m_done. Minimum gap back to IDLE: 1 cycle after rsp handshake.
- req_valid deasserted before grant simply drops out of arbitration; after req_ready, the slot data is no longer sampled.
- Only one transaction in flight; no queuing.

Decomposition:
- Package i2c_pkg: state enum arb_state_t; I2C_ADDR_W=7, I2C_DATA_W=8; typedef struct i2c_txn_t {addr, rw, wdata}; response struct i2c_rsp_t {rdata, ack_err, timeout}.
- Sub-module rr_arbiter (N parameter): combinational first-set search from pointer, with output grant_valid and grant_idx. Pointer register stays in the parent.

Test Plan:
- Single write: req 0 valid, addr 0x50, rw 0, wdata 0xA5; model done after 20 cycles with ack_err=0 -> one m_start, m_addr=0x50, m_wdata=0xA5; rsp_valid=01 with rsp_ack_err=0, rsp_timeout=0.
- Read: req 1, addr 0x68, rw 1; model returns rdata 0x3C -> rsp_valid=10, rsp_rdata=0x3C, held 5 cycles until rsp_ready[1] is asserted.
- Contention: both valid continuously for 4 transactions from reset -> grant order 0,1,0,1; exactly one m_start per grant.
- NACK: model done with m_ack_error=1 -> rsp_ack_err=1, rsp_timeout=0, and the next grant proceeds normally.
- Timeout with TIMEOUT_CYCLES=16 and no done -> rsp_timeout=1 exactly 16 cycles after m_start. Then hold m_busy=1 for 10 more cycles -> no new grant until m_busy=0; a late m_done is ignored.
- Reset mid-WAIT_DONE -> all outputs 0 the next cycle; no rsp_valid; requester 0 is granted first afterward.

Source files
------------

// File: rtl/i2c_bus_arbiter_pkg.sv
// Shared types for the I2C engine arbiter: FSM states, latched transaction and response records.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_RESP,
    ST_DRAIN
  } arb_state_t;

  typedef struct packed {
    logic [I2C_ADDR_W-1:0] addr;
    logic                  rw;
    logic [I2C_DATA_W-1:0] wdata;
  } i2c_txn_t;

  typedef struct packed {
    logic [I2C_DATA_W-1:0] rdata;
    logic                  ack_err;
    logic                  timeout;
  } i2c_rsp_t;

  // Index width for n requesters; a single requester still needs a 1-bit id.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// Requester handshake, response and i2c_master engine signals of the arbiter.
interface i2c_bus_arbiter_if
  import i2c_pkg::*;
#(
  parameter int N_REQ = 2
);

  localparam int GID_W = id_width(N_REQ);

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ready;
  logic [I2C_ADDR_W*N_REQ-1:0] req_addr;
  logic [N_REQ-1:0]            req_rw;
  logic [I2C_DATA_W*N_REQ-1:0] req_wdata;

  logic [N_REQ-1:0]            rsp_valid;
  logic [N_REQ-1:0]            rsp_ready;
  logic [I2C_DATA_W-1:0]       rsp_rdata;
  logic                        rsp_ack_err;
  logic                        rsp_timeout;

  logic                        m_start;
  logic [I2C_ADDR_W-1:0]       m_addr;
  logic                        m_rw;
  logic [I2C_DATA_W-1:0]       m_wdata;
  logic                        m_busy;
  logic                        m_done;
  logic                        m_ack_error;
  logic [I2C_DATA_W-1:0]       m_rdata;

  logic [GID_W-1:0]            grant_id;

  // Arbiter view.
  modport slave (
    input  req_valid, req_addr, req_rw, req_wdata, rsp_ready,
           m_busy, m_done, m_ack_error, m_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_ack_err, rsp_timeout,
           m_start, m_addr, m_rw, m_wdata, grant_id
  );

  // Requesters plus engine view.
  modport master (
    output req_valid, req_addr, req_rw, req_wdata, rsp_ready,
           m_busy, m_done, m_ack_error, m_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_ack_err, rsp_timeout,
           m_start, m_addr, m_rw, m_wdata, grant_id
  );

endinterface

// File: rtl/i2c_bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester set at or above i_ptr, wrapping around.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = i2c_pkg::id_width(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_grant_valid,
  output logic [IDX_W-1:0] o_grant_idx
);

  logic [N-1:0]   w_rot;
  logic [IDX_W-1:0] w_off;
  logic [IDX_W:0]   w_sum;

  // Rotating the doubled request vector puts the pointer's requester at bit 0.
  assign w_rot = N'({i_req, i_req} >> i_ptr);

  always_comb begin
    o_grant_valid = |i_req;
    w_off         = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = k[IDX_W-1:0];
    end
    w_sum = {1'b0, i_ptr} + {1'b0, w_off};
    if (w_sum >= (IDX_W+1)'(N)) w_sum = w_sum - (IDX_W+1)'(N);
    o_grant_idx = w_sum[IDX_W-1:0];
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin owner of one i2c_master engine: grant, start, await done or timeout, return response.
module i2c_bus_arbiter
  import i2c_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  i2c_bus_arbiter_if.slave  bus
);

  localparam int GID_W = id_width(N_REQ);

  arb_state_t       r_state;
  arb_state_t       w_state_next;
  logic [GID_W-1:0] r_ptr;
  logic [GID_W-1:0] r_gid;
  logic [CNT_W-1:0] r_cnt;
  i2c_txn_t         r_txn;
  i2c_rsp_t         r_rsp;

  logic             w_grant_valid;
  logic [GID_W-1:0] w_grant_idx;
  logic             w_grant;
  logic             w_done_cap;
  logic             w_timeout;
  logic             w_rsp_hs;
  i2c_txn_t         w_sel_txn;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (GID_W)
  ) u_rr_arbiter (
    .i_req         (bus.req_valid),
    .i_ptr         (r_ptr),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_done_cap   = 1'b0;
    w_timeout    = 1'b0;
    w_rsp_hs     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_grant_valid && !bus.m_busy) begin
          w_grant      = 1'b1;
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: w_state_next = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        // A done arriving on the last allowed cycle beats the timeout.
        if (bus.m_done) begin
          w_done_cap   = 1'b1;
          w_state_next = ST_RESP;
        end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_timeout    = 1'b1;
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready[r_gid]) begin
          w_rsp_hs     = 1'b1;
          w_state_next = r_rsp.timeout ? ST_DRAIN : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (!bus.m_busy) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_sel_txn = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant_idx == GID_W'(i)) begin
        w_sel_txn.addr  = bus.req_addr[i*I2C_ADDR_W +: I2C_ADDR_W];
        w_sel_txn.rw    = bus.req_rw[i];
        w_sel_txn.wdata = bus.req_wdata[i*I2C_DATA_W +: I2C_DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_gid   <= '0;
      r_cnt   <= '0;
      // NOTE: the latched transaction and response drive outputs directly, so they are reset too.
      r_txn   <= '0;
      r_rsp   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant) begin
        r_gid <= w_grant_idx;
        r_txn <= w_sel_txn;
      end
      if (r_state == ST_ISSUE) begin
        r_cnt <= '0;
      end else if (r_state == ST_WAIT_DONE) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_done_cap) begin
        r_rsp <= '{rdata: bus.m_rdata, ack_err: bus.m_ack_error, timeout: 1'b0};
      end else if (w_timeout) begin
        r_rsp <= '{rdata: '0, ack_err: 1'b0, timeout: 1'b1};
      end
      if (w_rsp_hs) begin
        r_ptr <= (r_gid == GID_W'(N_REQ - 1)) ? '0 : r_gid + 1'b1;
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    if (w_grant && !rst) bus.req_ready[w_grant_idx] = 1'b1;
    if (r_state == ST_RESP) bus.rsp_valid[r_gid] = 1'b1;
  end

  assign bus.m_start     = (r_state == ST_ISSUE);
  assign bus.m_addr      = r_txn.addr;
  assign bus.m_rw        = r_txn.rw;
  assign bus.m_wdata     = r_txn.wdata;
  assign bus.rsp_rdata   = r_rsp.rdata;
  assign bus.rsp_ack_err = r_rsp.ack_err;
  assign bus.rsp_timeout = r_rsp.timeout;
  assign bus.grant_id    = r_gid;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter: table of transactions plus timeout, drain and reset sequences.
module tb_i2c_bus_arbiter;
  import i2c_pkg::*;

  localparam int N   = 2;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  i2c_bus_arbiter_if #(.N_REQ(N)) bus ();

  i2c_bus_arbiter #(
    .N_REQ          (N),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0] valid;
    logic [6:0] a0;
    logic [6:0] a1;
    logic [1:0] rw;
    logic [7:0] w0;
    logic [7:0] w1;
    int         done_dly;
    logic       ack;
    logic [7:0] rdata;
    int         hold;
    int         exp_g;
    logic [6:0] exp_addr;
    logic       exp_rw;
    logic [7:0] exp_wdata;
    logic       exp_ack;
    logic [7:0] exp_rdata;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int n_start  = 0;
  int n_rsp    = 0;

  always @(posedge clk) begin
    if (bus.m_start === 1'b1) n_start++;
    if (bus.rsp_valid !== 2'b00) n_rsp++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_grant(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.req_ready !== 2'b00) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_txn(input vec_t v);
    logic [1:0] onehot;
    bit         seen;
    int         start_before;
    onehot         = 2'b01 << v.exp_g;
    bus.req_valid  = v.valid;
    bus.req_addr   = {v.a1, v.a0};
    bus.req_rw     = v.rw;
    bus.req_wdata  = {v.w1, v.w0};
    start_before   = n_start;
    wait_grant(seen);
    check("grant_seen", 32'(seen), 32'd1);
    check("req_ready", 32'(bus.req_ready), 32'(onehot));
    @(negedge clk);
    check("grant_id", 32'(bus.grant_id), v.exp_g);
    check("m_start", 32'(bus.m_start), 32'd1);
    check("m_addr", 32'(bus.m_addr), 32'(v.exp_addr));
    check("m_rw", 32'(bus.m_rw), 32'(v.exp_rw));
    check("m_wdata", 32'(bus.m_wdata), 32'(v.exp_wdata));
    bus.m_busy = 1'b1;
    repeat (v.done_dly) @(negedge clk);
    bus.m_done      = 1'b1;
    bus.m_ack_error = v.ack;
    bus.m_rdata     = v.rdata;
    @(negedge clk);
    bus.m_done      = 1'b0;
    bus.m_busy      = 1'b0;
    bus.m_ack_error = 1'b0;
    bus.m_rdata     = 8'hEE;
    check("rsp_valid", 32'(bus.rsp_valid), 32'(onehot));
    check("rsp_rdata", 32'(bus.rsp_rdata), 32'(v.exp_rdata));
    check("rsp_ack_err", 32'(bus.rsp_ack_err), 32'(v.exp_ack));
    check("rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
    if (v.hold > 0) begin
      bus.rsp_ready = ~onehot;
      repeat (v.hold) @(negedge clk);
      check("rsp_valid_held", 32'(bus.rsp_valid), 32'(onehot));
      check("rsp_rdata_held", 32'(bus.rsp_rdata), 32'(v.exp_rdata));
    end
    bus.rsp_ready = onehot;
    @(negedge clk);
    bus.rsp_ready = 2'b00;
    check("rsp_cleared", 32'(bus.rsp_valid), 32'd0);
    check("m_addr_stable", 32'(bus.m_addr), 32'(v.exp_addr));
    check("one_m_start", n_start - start_before, 32'd1);
  endtask

  vec_t vecs[8];
  vec_t v_drain;
  vec_t v_pre;
  vec_t v_post;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    int lat;
    int n_bad_ready;
    int n_bad_rsp;
    int rsp_before;

    // Fields: valid a0 a1 rw w0 w1 done_dly ack rdata hold | exp_g exp_addr exp_rw exp_wdata exp_ack exp_rdata
    vecs[0] = '{2'b11, 7'h50, 7'h51, 2'b00, 8'h11, 8'h22, 3,  1'b0, 8'h00, 0, 0, 7'h50, 1'b0, 8'h11, 1'b0, 8'h00};
    vecs[1] = '{2'b11, 7'h50, 7'h51, 2'b00, 8'h11, 8'h22, 4,  1'b0, 8'h00, 0, 1, 7'h51, 1'b0, 8'h22, 1'b0, 8'h00};
    vecs[2] = '{2'b11, 7'h50, 7'h51, 2'b00, 8'h11, 8'h22, 5,  1'b0, 8'h00, 0, 0, 7'h50, 1'b0, 8'h11, 1'b0, 8'h00};
    vecs[3] = '{2'b11, 7'h50, 7'h51, 2'b00, 8'h11, 8'h22, 6,  1'b0, 8'h00, 0, 1, 7'h51, 1'b0, 8'h22, 1'b0, 8'h00};
    vecs[4] = '{2'b01, 7'h50, 7'h00, 2'b00, 8'hA5, 8'h00, 12, 1'b0, 8'h00, 0, 0, 7'h50, 1'b0, 8'hA5, 1'b0, 8'h00};
    vecs[5] = '{2'b10, 7'h00, 7'h68, 2'b10, 8'h00, 8'h00, 8,  1'b0, 8'h3C, 5, 1, 7'h68, 1'b1, 8'h00, 1'b0, 8'h3C};
    vecs[6] = '{2'b01, 7'h2A, 7'h00, 2'b00, 8'h5A, 8'h00, 2,  1'b1, 8'h00, 0, 0, 7'h2A, 1'b0, 8'h5A, 1'b1, 8'h00};
    vecs[7] = '{2'b11, 7'h10, 7'h11, 2'b01, 8'h00, 8'h77, 16, 1'b0, 8'h99, 0, 1, 7'h11, 1'b0, 8'h77, 1'b0, 8'h99};
    v_drain = '{2'b11, 7'h01, 7'h12, 2'b00, 8'h00, 8'h34, 7,  1'b0, 8'h81, 0, 1, 7'h12, 1'b0, 8'h34, 1'b0, 8'h81};
    v_pre   = '{2'b01, 7'h44, 7'h00, 2'b00, 8'hC3, 8'h00, 2,  1'b0, 8'h81, 0, 0, 7'h44, 1'b0, 8'hC3, 1'b0, 8'h81};
    v_post  = '{2'b11, 7'h21, 7'h22, 2'b00, 8'h01, 8'h02, 3,  1'b0, 8'h00, 0, 0, 7'h21, 1'b0, 8'h01, 1'b0, 8'h00};

    rst             = 1'b1;
    bus.req_valid   = 2'b11;
    bus.req_addr    = '0;
    bus.req_rw      = '0;
    bus.req_wdata   = '0;
    bus.rsp_ready   = '0;
    bus.m_busy      = 1'b0;
    bus.m_done      = 1'b0;
    bus.m_ack_error = 1'b0;
    bus.m_rdata     = 8'hEE;
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_m_start", 32'(bus.m_start), 32'd0);
    check("rst_grant_id", 32'(bus.grant_id), 32'd0);
    check("rst_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Contention, single write, read with delayed consume, NACK, done on the timeout's last cycle.
    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Timeout with no done, then DRAIN while the engine stays busy.
    bus.req_valid = 2'b01;
    bus.req_addr  = {7'h00, 7'h3A};
    bus.req_rw    = 2'b00;
    bus.req_wdata = {8'h00, 8'h0F};
    wait_grant(seen);
    check("tmo_grant_seen", 32'(seen), 32'd1);
    check("tmo_req_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    check("tmo_m_start", 32'(bus.m_start), 32'd1);
    bus.m_busy    = 1'b1;
    bus.req_valid = 2'b00;
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 2'b00) begin
        lat = k;
        break;
      end
    end
    check("timeout_latency", lat, TMO + 1);
    check("tmo_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("tmo_rsp_timeout", 32'(bus.rsp_timeout), 32'd1);
    check("tmo_rsp_ack_err", 32'(bus.rsp_ack_err), 32'd0);
    check("tmo_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    bus.rsp_ready = 2'b01;
    @(negedge clk);
    bus.rsp_ready = 2'b00;
    check("tmo_rsp_cleared", 32'(bus.rsp_valid), 32'd0);
    bus.req_valid = 2'b11;
    bus.req_addr  = {7'h12, 7'h01};
    n_bad_ready   = 0;
    n_bad_rsp     = 0;
    for (int k = 0; k < 10; k++) begin
      bus.m_done      = (k == 4);
      bus.m_ack_error = (k == 4);
      bus.m_rdata     = (k == 4) ? 8'h55 : 8'hEE;
      #1;
      if (bus.req_ready !== 2'b00) n_bad_ready++;
      if (bus.rsp_valid !== 2'b00) n_bad_rsp++;
      @(negedge clk);
    end
    bus.m_done      = 1'b0;
    bus.m_ack_error = 1'b0;
    bus.m_rdata     = 8'hEE;
    check("drain_no_grant", n_bad_ready, 32'd0);
    check("drain_no_rsp", n_bad_rsp, 32'd0);
    check("late_done_ignored", 32'(bus.rsp_timeout), 32'd1);
    bus.m_busy = 1'b0;
    run_txn(v_drain);

    // Reset while WAIT_DONE, with the pointer favouring requester 1 beforehand.
    run_txn(v_pre);
    bus.req_valid = 2'b01;
    bus.req_addr  = {7'h00, 7'h45};
    bus.req_wdata = {8'h00, 8'h3C};
    wait_grant(seen);
    check("rst_txn_grant_seen", 32'(seen), 32'd1);
    @(negedge clk);
    bus.m_busy    = 1'b1;
    bus.req_valid = 2'b11;
    repeat (5) @(negedge clk);
    rsp_before = n_rsp;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("mid_rst_rsp_ack_err", 32'(bus.rsp_ack_err), 32'd0);
    check("mid_rst_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
    check("mid_rst_m_start", 32'(bus.m_start), 32'd0);
    check("mid_rst_m_addr", 32'(bus.m_addr), 32'd0);
    check("mid_rst_m_rw", 32'(bus.m_rw), 32'd0);
    check("mid_rst_m_wdata", 32'(bus.m_wdata), 32'd0);
    check("mid_rst_grant_id", 32'(bus.grant_id), 32'd0);
    bus.m_busy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_no_rsp", n_rsp - rsp_before, 32'd0);
    run_txn(v_post);
    bus.req_valid = 2'b00;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
